mux_4to1_rr: RTL and testbench



---
 rtl/mux_4to1_rr.sv | 97 +++++++++
 tb/tb_mux_4to1_rr.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_4to1_rr.sv
// Four-channel valid/ready merge into a one-deep registered output, with a
// round-robin arbiter; defining MUX_FIXED_PRIO_EN selects fixed priority ch0 > ch3.
module mux_4to1_rr #(
    parameter int width = 8,
    parameter int snum  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] i0,
    input  logic [width-1:0] i1,
    input  logic [width-1:0] i2,
    input  logic [width-1:0] i3,
    input  logic             v0,
    input  logic             v1,
    input  logic             v2,
    input  logic             v3,
    output logic             r0,
    output logic             r1,
    output logic             r2,
    output logic             r3,
    output logic [width-1:0] o,
    output logic [snum-1:0]  o_sel,
    output logic             o_valid,
    input  logic             o_ready
);

    // Handshakes: a word moves on any edge where valid and ready are both high;
    // valid never waits on ready, and a holder keeps its data stable until it moves.
    logic [3:0]       v;
    logic [3:0]       r;
    logic [width-1:0] din [4];
    logic             load;
    logic             grant;
    logic [snum-1:0]  g;
    logic [snum-1:0]  start;

    assign v       = {v3, v2, v1, v0};
    assign din[0]  = i0;
    assign din[1]  = i1;
    assign din[2]  = i2;
    assign din[3]  = i3;
    assign load    = ~o_valid | o_ready;

`ifdef MUX_FIXED_PRIO_EN
    assign start = '0;
`else
    logic [snum-1:0] ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (load && grant) begin
            ptr <= g + snum'(1);
        end
    end

    assign start = ptr;
`endif

    // Scan channels starting at the search origin; the first valid one wins.
    always_comb begin
        logic [snum-1:0] idx;
        grant = 1'b0;
        g     = '0;
        idx   = '0;
        for (int k = 0; k < 4; k++) begin
            idx = start + snum'(k);
            if (!grant && v[idx]) begin
                grant = 1'b1;
                g     = idx;
            end
        end
    end

    assign r  = (load && grant && !rst) ? (4'b0001 << g) : 4'b0000;
    assign r0 = r[0];
    assign r1 = r[1];
    assign r2 = r[2];
    assign r3 = r[3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o       <= '0;
            o_sel   <= '0;
            o_valid <= 1'b0;
        end else if (load) begin
            if (grant) begin
                o       <= din[g];
                o_sel   <= g;
                o_valid <= 1'b1;
            end else begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_4to1_rr.sv
// Bench for mux_4to1_rr: behavioural model with per-cycle compare, a word
// scoreboard, directed scenarios and randomized traffic.
module tb_mux_4to1_rr;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din [4];
    logic [3:0] v = 4'b0000;
    logic       o_ready = 1'b1;
    logic       r0, r1, r2, r3;
    logic [7:0] o;
    logic [1:0] o_sel;
    logic       o_valid;
    logic [3:0] r;

    int checks = 0;
    int failures = 0;
    logic [9:0] exp_q[$];

    // model state (m_*) and its value after the coming edge (n_*)
    int         m_ptr = 0, n_ptr = 0;
    logic       m_valid = 1'b0, n_valid = 1'b0;
    logic [7:0] m_o = 8'h00, n_o = 8'h00;
    logic [1:0] m_sel = 2'd0, n_sel = 2'd0;

    assign r = {r3, r2, r1, r0};

    mux_4to1_rr #(.width(8), .snum(2)) dut (
        .clk(clk), .rst(rst),
        .i0(din[0]), .i1(din[1]), .i2(din[2]), .i3(din[3]),
        .v0(v[0]), .v1(v[1]), .v2(v[2]), .v3(v[3]),
        .r0(r0), .r1(r1), .r2(r2), .r3(r3),
        .o(o), .o_sel(o_sel), .o_valid(o_valid), .o_ready(o_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare process: outputs against the model, plus the word scoreboard.
    always @(negedge clk) begin : cmp
        int         win;
        int         c;
        int         origin;
        logic       load;
        logic [3:0] exp_r;
        logic [9:0] w;
        if (rst) begin
            chk("rst_o", o, 0);
            chk("rst_o_sel", o_sel, 0);
            chk("rst_o_valid", o_valid, 0);
            chk("rst_r", r, 0);
            m_valid = 0; m_o = 0; m_sel = 0; m_ptr = 0;
            n_valid = 0; n_o = 0; n_sel = 0; n_ptr = 0;
            exp_q.delete();
        end else begin
            chk("o_valid", o_valid, m_valid);
            chk("o", o, m_o);
            chk("o_sel", o_sel, m_sel);
`ifdef MUX_FIXED_PRIO_EN
            origin = 0;
`else
            origin = m_ptr;
`endif
            load = !m_valid || o_ready;
            win = -1;
            for (int k = 0; k < 4; k++) begin
                c = (origin + k) % 4;
                if (win < 0 && v[c]) win = c;
            end
            exp_r = (load && win >= 0) ? 4'(1 << win) : 4'b0000;
            chk("r", r, exp_r);
            if (o_valid && o_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_empty: got word %0h expected none at %0t", {o_sel, o}, $time);
                end else begin
                    w = exp_q.pop_front();
                    chk("sb_word", {o_sel, o}, w);
                end
            end
            for (int k = 0; k < 4; k++)
                if (v[k] && r[k]) exp_q.push_back({2'(k), din[k]});
            n_valid = m_valid; n_o = m_o; n_sel = m_sel; n_ptr = m_ptr;
            if (load) begin
                if (win >= 0) begin
                    n_valid = 1;
                    n_o = din[win];
                    n_sel = 2'(win);
                    n_ptr = (win + 1) % 4;
                end else begin
                    n_valid = 0;
                end
            end
        end
    end

    always @(posedge clk) begin
        m_valid = n_valid; m_o = n_o; m_sel = n_sel; m_ptr = n_ptr;
    end

    task automatic set_step_data();
        din[0] = 8'hA0; din[1] = 8'hB0; din[2] = 8'hC0; din[3] = 8'hD0;
    endtask

    task automatic expect_word(input string name, input logic [1:0] sel, input logic [7:0] data);
        chk({name, "_valid"}, o_valid, 1);
        chk({name, "_sel"}, o_sel, sel);
        chk({name, "_data"}, o, data);
    endtask

    initial begin
        set_step_data();
        rst = 1'b1;
        tick();
        chk("init_valid", o_valid, 0);
        tick();
        rst = 1'b0;
        o_ready = 1'b1;

        // single channels, then drain
        v = 4'b0001; tick(); expect_word("single0", 2'd0, 8'hA0);
        v = 4'b0010; tick(); expect_word("single1", 2'd1, 8'hB0);
        v = 4'b0100; tick(); expect_word("single2", 2'd2, 8'hC0);
        v = 4'b1000; tick(); expect_word("single3", 2'd3, 8'hD0);
        v = 4'b0000; tick();
        chk("drain_valid", o_valid, 0);
        chk("drain_hold", o, 8'hD0);

        // all channels requesting
        v = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            tick();
`ifdef MUX_FIXED_PRIO_EN
            expect_word("all_req", 2'd0, 8'hA0);
`else
            expect_word("all_req", 2'(k % 4), 8'hA0 + 8'(16 * (k % 4)));
`endif
        end

        // backpressure
        v = 4'b0001; tick(); expect_word("bp_load", 2'd0, 8'hA0);
        v = 4'b0110; o_ready = 1'b0; #1;
        chk("bp_r", r, 4'b0000);
        for (int k = 0; k < 5; k++) begin
            tick();
            expect_word("bp_hold", 2'd0, 8'hA0);
            chk("bp_r_hold", r, 4'b0000);
        end
        o_ready = 1'b1; #1;
        chk("bp_release_r", r, 4'b0010);
        tick(); expect_word("bp_b0", 2'd1, 8'hB0);
        v = 4'b0100; tick(); expect_word("bp_c0", 2'd2, 8'hC0);

        // wrap from ch3 back to ch0
        v = 4'b1001; tick();
`ifdef MUX_FIXED_PRIO_EN
        expect_word("wrap_first", 2'd0, 8'hA0);
`else
        expect_word("wrap_first", 2'd3, 8'hD0);
`endif
        tick(); expect_word("wrap_second", 2'd0, 8'hA0);
        v = 4'b0100; tick(); expect_word("wrap_ch2", 2'd2, 8'hC0);
        v = 4'b0000; tick();
        chk("wrap_drain", o_valid, 0);
        chk("wrap_drain_hold", o, 8'hC0);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 4; k++) din[k] = 8'($urandom_range(0, 255));
            v = 4'($urandom_range(0, 15));
            o_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        // reset mid-stream with a word held
        set_step_data();
        v = 4'b1111; o_ready = 1'b0; tick();
        chk("pre_rst_valid", o_valid, 1);
        rst = 1'b1; #1;
        chk("mid_rst_o", o, 0);
        chk("mid_rst_sel", o_sel, 0);
        chk("mid_rst_valid", o_valid, 0);
        chk("mid_rst_r", r, 0);
        o_ready = 1'b1;
        tick(); tick();
        rst = 1'b0; #1;
        chk("post_rst_r", r, 4'b0001);
        tick(); expect_word("post_rst_first", 2'd0, 8'hA0);

        // final drain
        v = 4'b0000; o_ready = 1'b1;
        tick(); tick(); tick();
        chk("final_valid", o_valid, 0);
        chk("final_queue", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
